// File: rtl/tour_cmd_seq_pkg.sv
// Shared types and constants for the tour command sequencer.
package tour_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEG1  = 3'd1,
        S_WAIT1 = 3'd2,
        S_LEG2  = 3'd3,
        S_WAIT2 = 3'd4
    } state_t;

    localparam logic [3:0] OP_MOVE    = 4'h4;
    localparam logic [3:0] OP_FANFARE = 4'h5;

    localparam logic [7:0] HEAD_N = 8'h00;
    localparam logic [7:0] HEAD_W = 8'h3F;
    localparam logic [7:0] HEAD_S = 8'h7F;
    localparam logic [7:0] HEAD_E = 8'hBF;

    localparam logic [7:0] RESP_DONE = 8'hA5;
    localparam logic [7:0] RESP_BUSY = 8'h5A;

    // True when exactly one bit of the move vector is set.
    function automatic logic is_one_hot(input logic [7:0] v);
        return (v != 8'h00) && ((v & (v - 8'd1)) == 8'h00);
    endfunction

endpackage

// File: rtl/tour_cmd_seq_decode.sv
// Combinational decode of a one-hot knight move into its vertical and
// horizontal single-axis move commands (plain move opcode on both).
module tour_move_decode
    import tour_pkg::*;
(
    input  logic [7:0]  move,
    output logic [15:0] vert_cmd,
    output logic [15:0] horz_cmd,
    output logic        valid
);

    logic [7:0] vert_head;
    logic [3:0] vert_sq;
    logic [7:0] horz_head;
    logic [3:0] horz_sq;

    // Look up heading and square count for each axis of the knight move.
    always_comb begin
        vert_head = HEAD_N;
        vert_sq   = 4'd0;
        horz_head = HEAD_E;
        horz_sq   = 4'd0;
        case (move)
            8'h01: begin vert_head = HEAD_N; vert_sq = 4'd2; horz_head = HEAD_E; horz_sq = 4'd1; end
            8'h02: begin vert_head = HEAD_N; vert_sq = 4'd1; horz_head = HEAD_E; horz_sq = 4'd2; end
            8'h04: begin vert_head = HEAD_N; vert_sq = 4'd1; horz_head = HEAD_W; horz_sq = 4'd2; end
            8'h08: begin vert_head = HEAD_N; vert_sq = 4'd2; horz_head = HEAD_W; horz_sq = 4'd1; end
            8'h10: begin vert_head = HEAD_S; vert_sq = 4'd2; horz_head = HEAD_W; horz_sq = 4'd1; end
            8'h20: begin vert_head = HEAD_S; vert_sq = 4'd1; horz_head = HEAD_W; horz_sq = 4'd2; end
            8'h40: begin vert_head = HEAD_S; vert_sq = 4'd1; horz_head = HEAD_E; horz_sq = 4'd2; end
            8'h80: begin vert_head = HEAD_S; vert_sq = 4'd2; horz_head = HEAD_E; horz_sq = 4'd1; end
            default: begin end
        endcase
        valid    = is_one_hot(move);
        vert_cmd = {OP_MOVE, vert_head, vert_sq};
        horz_cmd = {OP_MOVE, horz_head, horz_sq};
    end

endmodule

// File: rtl/tour_cmd_seq.sv
// Tour command sequencer: replays the solved move list as two single-axis
// legs per knight move through the cmd/cmd_rdy handshake, or passes UART
// commands through when no tour is running.
module tour_cmd_seq
    import tour_pkg::*;
#(
    parameter int NUM_MOVES    = 24,
    parameter int IDX_W        = $clog2(NUM_MOVES),
    parameter int LEG_ORDER    = 0,
    parameter int FANFARE_MODE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_tour,
    input  logic             abort,
    input  logic [7:0]       move,
    output logic [IDX_W-1:0] mv_indx,
    input  logic [15:0]      cmd_UART,
    input  logic             cmd_rdy_UART,
    output logic [15:0]      cmd,
    output logic             cmd_rdy,
    input  logic             clr_cmd_rdy,
    input  logic             send_resp,
    output logic [7:0]       resp,
    output logic             tour_busy,
    output logic             tour_done,
    output logic             mv_err
);

    state_t      state;
    state_t      next_state;
    logic [15:0] vert_cmd;
    logic [15:0] horz_cmd;
    logic        move_valid;
    logic        last_move;
    logic        fanfare_en;
    logic [15:0] leg1_cmd;
    logic [15:0] leg2_base;
    logic [15:0] leg2_cmd;
    logic        inc_idx;
    logic        set_err;
    logic        clear_err;
    logic        finish;

    tour_move_decode u_decode (
        .move     (move),
        .vert_cmd (vert_cmd),
        .horz_cmd (horz_cmd),
        .valid    (move_valid)
    );

    assign last_move  = (mv_indx == IDX_W'(NUM_MOVES - 1));
    assign fanfare_en = (FANFARE_MODE == 1) || ((FANFARE_MODE == 2) && last_move);
    assign leg1_cmd   = (LEG_ORDER == 0) ? vert_cmd : horz_cmd;
    assign leg2_base  = (LEG_ORDER == 0) ? horz_cmd : vert_cmd;
    assign leg2_cmd   = fanfare_en ? {OP_FANFARE, leg2_base[11:0]} : leg2_base;
    assign tour_busy  = (state != S_IDLE);

    // Next-state logic; abort outranks every other event outside IDLE.
    always_comb begin
        next_state = state;
        inc_idx    = 1'b0;
        set_err    = 1'b0;
        clear_err  = 1'b0;
        finish     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_tour && !abort) begin
                    clear_err  = 1'b1;
                    next_state = S_LEG1;
                end
            end
            S_LEG1: begin
                if (abort) begin
                    next_state = S_IDLE;
                end else if (!move_valid) begin
                    set_err    = 1'b1;
                    next_state = S_IDLE;
                end else if (clr_cmd_rdy) begin
                    next_state = S_WAIT1;
                end
            end
            S_WAIT1: begin
                if (abort)          next_state = S_IDLE;
                else if (send_resp) next_state = S_LEG2;
            end
            S_LEG2: begin
                if (abort)            next_state = S_IDLE;
                else if (clr_cmd_rdy) next_state = S_WAIT2;
            end
            S_WAIT2: begin
                if (abort) begin
                    next_state = S_IDLE;
                end else if (send_resp) begin
                    if (last_move) begin
                        finish     = 1'b1;
                        next_state = S_IDLE;
                    end else begin
                        inc_idx    = 1'b1;
                        next_state = S_LEG1;
                    end
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Output mux: UART passthrough in IDLE, leg commands while touring.
    always_comb begin
        cmd     = cmd_UART;
        cmd_rdy = 1'b0;
        resp    = RESP_BUSY;
        case (state)
            S_IDLE: begin
                cmd     = cmd_UART;
                cmd_rdy = cmd_rdy_UART;
                resp    = RESP_DONE;
            end
            S_LEG1: begin
                cmd     = leg1_cmd;
                cmd_rdy = move_valid && !abort;
            end
            S_WAIT1: begin
                cmd = leg1_cmd;
            end
            S_LEG2: begin
                cmd     = leg2_cmd;
                cmd_rdy = !abort;
                resp    = last_move ? RESP_DONE : RESP_BUSY;
            end
            S_WAIT2: begin
                cmd  = leg2_cmd;
                resp = last_move ? RESP_DONE : RESP_BUSY;
            end
            default: begin end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Move index: returns to zero whenever the FSM heads back to IDLE.
    always_ff @(posedge clk) begin
        if (rst)                       mv_indx <= '0;
        else if (next_state == S_IDLE) mv_indx <= '0;
        else if (inc_idx)              mv_indx <= mv_indx + IDX_W'(1);
    end

    // Sticky illegal-move flag, cleared only by reset or a new tour.
    always_ff @(posedge clk) begin
        if (rst)            mv_err <= 1'b0;
        else if (clear_err) mv_err <= 1'b0;
        else if (set_err)   mv_err <= 1'b1;
    end

    // Completion pulse, high in the first IDLE cycle after a full tour.
    always_ff @(posedge clk) begin
        if (rst) tour_done <= 1'b0;
        else     tour_done <= finish;
    end

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Self-checking bench for tour_cmd_seq: two instances (vertical-first with
// fanfare on every move, horizontal-first with fanfare on the final move)
// replay the same handshake timing and are compared to a reference model.
module tb_tour_cmd_seq;

    localparam int NM    = 4;
    localparam int TOTAL = 2 * NM;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start_tour, abort, clr_cmd_rdy, send_resp, cmd_rdy_UART;
    logic [15:0] cmd_UART;
    logic [7:0]  mem_a [NM];
    logic [7:0]  mem_b [NM];
    logic [7:0]  move_a, move_b;
    logic [1:0]  mv_indx_a, mv_indx_b;
    logic [15:0] cmd_a, cmd_b;
    logic        cmd_rdy_a, cmd_rdy_b;
    logic [7:0]  resp_a, resp_b;
    logic        busy_a, busy_b, done_a, done_b, err_a, err_b;

    assign move_a = mem_a[mv_indx_a];
    assign move_b = mem_b[mv_indx_b];

    tour_cmd_seq #(.NUM_MOVES(NM), .LEG_ORDER(0), .FANFARE_MODE(1)) dut_a (
        .clk(clk), .rst(rst), .start_tour(start_tour), .abort(abort),
        .move(move_a), .mv_indx(mv_indx_a), .cmd_UART(cmd_UART),
        .cmd_rdy_UART(cmd_rdy_UART), .cmd(cmd_a), .cmd_rdy(cmd_rdy_a),
        .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .resp(resp_a),
        .tour_busy(busy_a), .tour_done(done_a), .mv_err(err_a));

    tour_cmd_seq #(.NUM_MOVES(NM), .LEG_ORDER(1), .FANFARE_MODE(2)) dut_b (
        .clk(clk), .rst(rst), .start_tour(start_tour), .abort(abort),
        .move(move_b), .mv_indx(mv_indx_b), .cmd_UART(cmd_UART),
        .cmd_rdy_UART(cmd_rdy_UART), .cmd(cmd_b), .cmd_rdy(cmd_rdy_b),
        .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .resp(resp_b),
        .tour_busy(busy_b), .tour_done(done_b), .mv_err(err_b));

    typedef struct {
        logic [7:0]  mv;
        logic [15:0] leg1;
        logic [15:0] leg2;
    } move_vec_t;

    typedef struct {
        logic [15:0] ucmd;
        logic        urdy;
        logic [15:0] exp_cmd;
        logic        exp_rdy;
        logic [7:0]  exp_resp;
    } idle_vec_t;

    move_vec_t   mtab [8];
    idle_vec_t   itab [4];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] got_a [$];
    logic [15:0] got_b [$];
    logic [7:0]  got_resp [$];
    logic        got_rdy_b [$];
    logic [15:0] exp_a [$];
    logic [15:0] exp_b [$];
    int          done_cnt;

    // Compare one value and report a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Reference model: leg command from the knight move geometry.
    function automatic logic [15:0] modelCmd(input logic [7:0] mv, input int leg,
                                             input bit last, input int order, input int fan);
        int dx [8];
        int dy [8];
        int k, ax, ay;
        logic [15:0] v, h, c;
        dx = '{1, 2, -2, -1, -1, -2, 2, 1};
        dy = '{2, 1, 1, 2, -2, -1, -1, -2};
        k = 0;
        for (int i = 0; i < 8; i++) if (mv[i]) k = i;
        ax = (dx[k] < 0) ? -dx[k] : dx[k];
        ay = (dy[k] < 0) ? -dy[k] : dy[k];
        v = {4'h4, (dy[k] > 0) ? 8'h00 : 8'h7F, 4'(ay)};
        h = {4'h4, (dx[k] > 0) ? 8'hBF : 8'h3F, 4'(ax)};
        c = (((leg == 1) ? 1 : 0) == ((order == 0) ? 1 : 0)) ? v : h;
        if (leg == 2 && (fan == 1 || (fan == 2 && last))) c[15:12] = 4'h5;
        return c;
    endfunction

    function automatic void buildExpB();
        exp_b.delete();
        for (int i = 0; i < NM; i++)
            for (int leg = 1; leg <= 2; leg++)
                exp_b.push_back(modelCmd(mem_b[i], leg, i == NM - 1, 1, 2));
    endfunction

    function automatic void buildExpA();
        exp_a.delete();
        for (int i = 0; i < NM; i++)
            for (int leg = 1; leg <= 2; leg++)
                exp_a.push_back(modelCmd(mem_a[i], leg, i == NM - 1, 0, 1));
    endfunction

    // Drive one idle-passthrough vector.
    task automatic applyStimulus(input idle_vec_t v);
        @(negedge clk);
        cmd_UART     = v.ucmd;
        cmd_rdy_UART = v.urdy;
        #1;
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst = 1'b1; start_tour = 1'b0; abort = 1'b0;
        clr_cmd_rdy = 1'b0; send_resp = 1'b0; cmd_rdy_UART = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Ideal (or randomly stalling) cmd_proc; returns early after stop_legs accepts.
    task automatic runTour(input int stop_legs, input bit rnd);
        int legs = 0;
        int cyc  = 0;
        bit pend = 0;
        int r;
        got_a.delete(); got_b.delete(); got_resp.delete(); got_rdy_b.delete();
        done_cnt = 0;
        forever begin
            @(negedge clk);
            start_tour = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0;
            #1;
            if (done_a) done_cnt++;
            if (legs == TOTAL && !busy_a) break;
            if (cyc++ > 500) begin
                n_checks++; n_fail++;
                $display("[TB] FAIL tour timeout: got legs %0d expected %0d", legs, TOTAL);
                break;
            end
            r = rnd ? int'($urandom_range(0, 3)) : 1;
            if (pend) begin
                if (r == 0) clr_cmd_rdy = 1'b1;
                else begin send_resp = 1'b1; pend = 0; end
            end else if (cmd_rdy_a) begin
                if (r == 0) send_resp = 1'b1;
                else begin
                    got_a.push_back(cmd_a); got_b.push_back(cmd_b);
                    got_resp.push_back(resp_a); got_rdy_b.push_back(cmd_rdy_b);
                    clr_cmd_rdy = 1'b1; pend = 1; legs++;
                    if (legs == stop_legs) return;
                end
            end
        end
    endtask

    task automatic checkTour(input string tag);
        checkOutput({tag, " leg count"}, got_a.size(), exp_a.size());
        for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
            checkOutput($sformatf("%s A cmd[%0d]", tag, i), got_a[i], exp_a[i]);
            checkOutput($sformatf("%s B cmd[%0d]", tag, i), got_b[i], exp_b[i]);
            checkOutput($sformatf("%s B rdy[%0d]", tag, i), got_rdy_b[i], 1);
            checkOutput($sformatf("%s resp[%0d]", tag, i), got_resp[i],
                        (i == TOTAL - 1) ? 8'hA5 : 8'h5A);
        end
        checkOutput({tag, " done pulses"}, done_cnt, 1);
        @(negedge clk); #1;
        checkOutput({tag, " done single"}, done_a, 0);
        checkOutput({tag, " idle resp"}, resp_a, 8'hA5);
    endtask

    task automatic startTour();
        @(negedge clk);
        start_tour = 1'b1;
    endtask

    initial begin
        mtab = '{'{8'h01, 16'h4002, 16'h5BF1}, '{8'h02, 16'h4001, 16'h5BF2},
                 '{8'h40, 16'h47F1, 16'h5BF2}, '{8'h80, 16'h47F2, 16'h5BF1},
                 '{8'h04, 16'h4001, 16'h53F2}, '{8'h08, 16'h4002, 16'h53F1},
                 '{8'h10, 16'h47F2, 16'h53F1}, '{8'h20, 16'h47F1, 16'h53F2}};
        itab = '{'{16'hA5A5, 1'b1, 16'hA5A5, 1'b1, 8'hA5},
                 '{16'hA5A5, 1'b0, 16'hA5A5, 1'b0, 8'hA5},
                 '{16'h1234, 1'b1, 16'h1234, 1'b1, 8'hA5},
                 '{16'h0000, 1'b0, 16'h0000, 1'b0, 8'hA5}};
        for (int i = 0; i < NM; i++) begin mem_a[i] = 8'h01; mem_b[i] = 8'h01; end

        rst = 1'b1; start_tour = 1'b0; abort = 1'b0; clr_cmd_rdy = 1'b0;
        send_resp = 1'b0; cmd_UART = 16'h0F0F; cmd_rdy_UART = 1'b1;
        @(negedge clk); @(negedge clk);
        rst = 1'b0; #1;
        checkOutput("reset busy", busy_a, 0);
        checkOutput("reset mv_indx", mv_indx_a, 0);
        checkOutput("reset mv_err", err_a, 0);
        checkOutput("reset done", done_a, 0);
        checkOutput("reset resp", resp_a, 8'hA5);
        checkOutput("reset cmd", cmd_a, 16'h0F0F);
        checkOutput("reset cmd_rdy", cmd_rdy_a, 1);

        $display("[TB] idle passthrough vectors");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(itab[i]);
            checkOutput($sformatf("idle cmd[%0d]", i), cmd_a, itab[i].exp_cmd);
            checkOutput($sformatf("idle rdy[%0d]", i), cmd_rdy_a, itab[i].exp_rdy);
            checkOutput($sformatf("idle resp[%0d]", i), resp_a, itab[i].exp_resp);
        end
        cmd_rdy_UART = 1'b0;

        $display("[TB] table-driven tours");
        for (int t = 0; t < 2; t++) begin
            exp_a.delete();
            for (int i = 0; i < NM; i++) begin
                mem_a[i] = mtab[t * NM + i].mv;
                mem_b[i] = mtab[t * NM + i].mv;
                exp_a.push_back(mtab[t * NM + i].leg1);
                exp_a.push_back(mtab[t * NM + i].leg2);
            end
            buildExpB();
            startTour();
            runTour(0, 0);
            checkTour($sformatf("table%0d", t));
        end

        $display("[TB] horizontal-first, final-only fanfare");
        for (int i = 0; i < NM; i++) begin mem_a[i] = 8'h08; mem_b[i] = 8'h08; end
        buildExpA();
        exp_b = '{16'h43F1, 16'h4002, 16'h43F1, 16'h4002,
                  16'h43F1, 16'h4002, 16'h43F1, 16'h5002};
        startTour();
        runTour(0, 0);
        checkTour("order1");

        $display("[TB] random tours with stalls and UART noise");
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < NM; i++) begin
                mem_a[i] = 8'h01 << $urandom_range(0, 7);
                mem_b[i] = 8'h01 << $urandom_range(0, 7);
            end
            buildExpA();
            buildExpB();
            cmd_UART = 16'hDEAD; cmd_rdy_UART = 1'b0;
            startTour();
            cmd_rdy_UART = 1'b1;
            runTour(0, 1);
            cmd_rdy_UART = 1'b0;
            checkTour($sformatf("rand%0d", t));
        end

        $display("[TB] abort in WAIT1 of move 2");
        applyReset();
        for (int i = 0; i < NM; i++) begin mem_a[i] = mtab[i].mv; mem_b[i] = mtab[i].mv; end
        startTour();
        runTour(5, 0);
        cmd_UART = 16'h1234; cmd_rdy_UART = 1'b0;
        @(negedge clk);
        clr_cmd_rdy = 1'b0; abort = 1'b1; send_resp = 1'b1; #1;
        checkOutput("abort cmd_rdy", cmd_rdy_a, 0);
        checkOutput("abort mv_indx before", mv_indx_a, 2);
        @(negedge clk);
        abort = 1'b0; send_resp = 1'b0; #1;
        checkOutput("abort busy", busy_a, 0);
        checkOutput("abort mv_indx", mv_indx_a, 0);
        checkOutput("abort done", done_a, 0);
        checkOutput("abort cmd", cmd_a, 16'h1234);
        checkOutput("abort resp", resp_a, 8'hA5);

        $display("[TB] abort in LEG1");
        startTour();
        @(negedge clk);
        start_tour = 1'b0; abort = 1'b1; #1;
        checkOutput("abort leg1 cmd_rdy", cmd_rdy_a, 0);
        @(negedge clk);
        abort = 1'b0; #1;
        checkOutput("abort leg1 busy", busy_a, 0);
        checkOutput("abort leg1 done", done_a, 0);

        $display("[TB] illegal move at index 1");
        applyReset();
        mem_a[0] = 8'h01; mem_a[1] = 8'h03;
        startTour();
        runTour(2, 0);
        @(negedge clk);
        clr_cmd_rdy = 1'b0; send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0; #1;
        checkOutput("err leg1 cmd_rdy", cmd_rdy_a, 0);
        checkOutput("err mv_indx", mv_indx_a, 1);
        @(negedge clk); #1;
        checkOutput("err mv_err", err_a, 1);
        checkOutput("err busy", busy_a, 0);
        checkOutput("err done", done_a, 0);
        mem_a[1] = 8'h02;
        @(negedge clk);
        start_tour = 1'b1; #1;
        checkOutput("err sticky", err_a, 1);
        @(negedge clk);
        start_tour = 1'b0; #1;
        checkOutput("err cleared", err_a, 0);
        checkOutput("restart cmd_rdy", cmd_rdy_a, 1);
        checkOutput("restart cmd", cmd_a, 16'h4002);

        $display("[TB] reset during LEG2");
        applyReset();
        startTour();
        runTour(1, 0);
        @(negedge clk);
        clr_cmd_rdy = 1'b0; send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0; #1;
        checkOutput("leg2 cmd_rdy", cmd_rdy_a, 1);
        checkOutput("leg2 cmd", cmd_a, 16'h5BF1);
        rst = 1'b1; clr_cmd_rdy = 1'b1; cmd_UART = 16'hBEEF; cmd_rdy_UART = 1'b0;
        @(negedge clk);
        rst = 1'b0; clr_cmd_rdy = 1'b0; #1;
        checkOutput("rst busy", busy_a, 0);
        checkOutput("rst mv_indx", mv_indx_a, 0);
        checkOutput("rst mv_err", err_a, 0);
        checkOutput("rst done", done_a, 0);
        checkOutput("rst resp", resp_a, 8'hA5);
        checkOutput("rst cmd", cmd_a, 16'hBEEF);
        checkOutput("rst cmd_rdy", cmd_rdy_a, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
